// File: rtl/buf_arb_pkg.sv
// Shared types and sizing helpers for the scratchpad write-port arbiter.
package buf_arb_pkg;

  localparam int BUFFER_WIDTH_DEF = 16;
  localparam int PAR_WRITE_DEF    = 4;
  localparam int NUM_REQ_DEF      = 2;
  localparam int MAX_BURST_DEF    = 8;

  // Width of one parallel-write packet at the default configuration.
  localparam int PKT_W = PAR_WRITE_DEF * BUFFER_WIDTH_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Burst-length field width; must hold MAX_BURST itself.
  function automatic int len_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Requester index width, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after `last`.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [N-1:0]  onehot
);

  logic [IW-1:0] idx;

  // Scan from last+1, wrapping, and keep only the first hit.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buf_write_arbiter.sv
// Burst-granular round-robin arbiter for the PE scratchpad parallel-write port.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no owner; pick the next requester after `last`
//  GRANT | gnt owns the port; cnt packets left, one per buf_ready cycle
module buf_write_arbiter
  import buf_arb_pkg::*;
#(
  parameter int BUFFER_WIDTH = BUFFER_WIDTH_DEF,
  parameter int PAR_WRITE    = PAR_WRITE_DEF,
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF,
  parameter int LEN_W        = len_w(MAX_BURST)
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  en,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*LEN_W-1:0]              req_len,
  input  logic [NUM_REQ*PAR_WRITE*BUFFER_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]                    gnt,
  output logic [NUM_REQ-1:0]                    req_ack,
  output logic [NUM_REQ-1:0]                    burst_done,
  output logic                                  buf_en,
  output logic                                  buf_wen,
  output logic [PAR_WRITE*BUFFER_WIDTH-1:0]     buf_din,
  input  logic                                  buf_ready
);

  localparam int DW = PAR_WRITE * BUFFER_WIDTH;
  localparam int IW = idx_w(NUM_REQ);

  arb_state_t          state;
  logic [IW-1:0]       last;
  logic [LEN_W-1:0]    cnt;

  logic                pick_valid;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [LEN_W-1:0]    pick_raw_len;
  logic [LEN_W-1:0]    pick_len;

  logic [IW-1:0]       cur_idx;
  logic [DW-1:0]       cur_din;
  logic                cur_req;
  logic                xfer;
  logic                last_pkt;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .onehot (pick_onehot)
  );

  // Length of the candidate winner, forced into the legal 1..MAX_BURST range.
  always_comb begin
    pick_raw_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_raw_len = req_len[i*LEN_W +: LEN_W];
      end
    end
    if (pick_raw_len == '0) begin
      pick_len = LEN_W'(1);
    end else if (pick_raw_len > LEN_W'(MAX_BURST)) begin
      pick_len = LEN_W'(MAX_BURST);
    end else begin
      pick_len = pick_raw_len;
    end
  end

  // Decode the current owner; data stays zero while nobody holds the grant.
  always_comb begin
    cur_idx = '0;
    cur_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        cur_idx = IW'(i);
        cur_din = req_din[i*DW +: DW];
      end
    end
  end

  // Buffer-side handshake and per-requester strobes.
  always_comb begin
    cur_req    = |(req & gnt);
    buf_en     = en;
    buf_wen    = en && (state == GRANT) && cur_req;
    buf_din    = cur_din;
    xfer       = buf_wen && buf_ready;
    last_pkt   = (cnt == LEN_W'(1));
    req_ack    = {NUM_REQ{xfer}} & gnt;
    burst_done = {NUM_REQ{xfer && last_pkt}} & gnt;
  end

  // Arbitration FSM; en low freezes every register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= '0;
      cnt   <= '0;
      last  <= IW'(NUM_REQ - 1);
    end else if (en) begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_onehot;
            cnt   <= pick_len;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            cnt <= cnt - LEN_W'(1);
            if (last_pkt) begin
              gnt   <= '0;
              last  <= cur_idx;
              state <= IDLE;
            end
          end else if (!cur_req) begin
            // Owner withdrew mid-burst: release without burst_done.
            gnt   <= '0;
            cnt   <= '0;
            last  <= cur_idx;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/buf_write_arbiter.md
# buf_write_arbiter

Round-robin arbiter that shares the single parallel-write port of a PE scratchpad buffer (PAR_WRITE words of BUFFER_WIDTH per write) between NUM_REQ requesters, e.g. ifmap and filter loaders. A winner is granted for a whole burst of packets. The arbiter drives the buffer's enable, write-enable and data inputs, and paces transfers on the buffer's ready output. It sits between the loaders and the buffer inside the PE top.

## Interface
- BUFFER_WIDTH, 16, bits per word
- PAR_WRITE, 4, words per write packet
- NUM_REQ, 2, number of requesters (≥2)
- MAX_BURST, 8, maximum packets per burst; LEN_W = $clog2(MAX_BURST+1)

- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes all state
- req  in  NUM_REQ  per-requester burst request
- req_len  in  NUM_REQ*LEN_W  burst length in packets; slice i belongs to requester i
- req_din  in  NUM_REQ*PAR_WRITE*BUFFER_WIDTH  current packet of each requester
- gnt  out  NUM_REQ  one-hot grant, registered
- req_ack  out  NUM_REQ  packet of requester i accepted this cycle
- burst_done  out  NUM_REQ  pulses with the final ack of a completed burst
- buf_en  out  1  buffer enable, equal to en
- buf_wen  out  1  buffer write enable
- buf_din  out  PAR_WRITE*BUFFER_WIDTH  packet to the buffer
- buf_ready  in  1  buffer can accept a packet this cycle

## Operation
- FSM states: IDLE, GRANT. State, gnt, the round-robin pointer `last` and the burst counter `cnt` are registered.
- IDLE, with en=1 and req≠0:
  - Winner = first requester with req set, searching from last+1 modulo NUM_REQ.
  - gnt ← onehot(winner); cnt ← req_len[winner]; state → GRANT.
  - req_len=0 is loaded as 1; req_len>MAX_BURST saturates to MAX_BURST.
- GRANT:
  - buf_wen = en & req[winner].
  - buf_din = req_din slice of the winner; all zeros whenever gnt=0.
  - Transfer = buf_wen & buf_ready.
  - On a transfer: req_ack[winner]=1 (combinational); cnt decrements. The requester presents its next packet after each ack.
  - If the transfer happens with cnt==1: burst_done[winner]=1 in the same cycle, last ← winner, gnt ← 0, state → IDLE.
- Abort: req[winner] falls in GRANT with no transfer that cycle.
  - Next edge: gnt ← 0, last ← winner, state → IDLE.
  - No burst_done is issued; packets already written remain in the buffer.
- en=0 forces buf_wen=0, req_ack=0 and burst_done=0, and holds all registers.
- Requesters not granted see req_ack=0; their req and data are ignored.

## Timing
- Reset (async, rstn=0) values:
  - state=IDLE, gnt=0, cnt=0, last=NUM_REQ-1, so requester 0 wins first.
  - buf_wen=0, buf_din=0, req_ack=0, burst_done=0.
- Arbitration latency: req seen in IDLE at edge k → gnt high after edge k. The first possible transfer is in cycle k+1.
- One packet per cycle while buf_ready=1. When buf_ready=0, buf_wen stays high and buf_din is held.
- A burst of N packets with no stalls takes N cycles in GRANT plus 1 IDLE bubble before the next grant.
- Simultaneous requests: strict rotation. With both requesters active, grants alternate 0,1,0,1.
- Reset mid-burst: state, gnt and cnt clear immediately. Outputs follow their reset values on the next evaluation, with no burst_done.
- A requester that re-raises req in the cycle of its own burst_done still loses to any other pending requester.

## Structure
- Package buf_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the LEN_W helper function;
  - the packet width constant PAR_WRITE*BUFFER_WIDTH.
- Sub-module rr_pick: combinational round-robin picker with inputs req and last, outputs a valid flag and a one-hot winner. All registers stay in buf_write_arbiter.

## Test plan
- Single burst: req[0]=1, req_len=3, packets {12,8,1,5}, {120,130,150,170}, {-3,-1,-4,-17}, buf_ready=1 → gnt=01 one cycle after req; three consecutive acks; buf_din matches each packet in order; burst_done[0] with the third ack; IDLE next.
- Stall: same burst with buf_ready low for 2 cycles before packet 2 → buf_wen stays 1 and buf_din holds {120,130,150,170}; no ack during the stall; total 5 GRANT cycles.
- Contention: req=11 held, both req_len=2 → grant sequence 0,1,0,1. Each grant is separated by one IDLE cycle and produces 2 acks.
- Abort: req[1] alone with req_len=4; req[1] drops after 2 acks → gnt=0 next edge, no burst_done. A new req[0] is granted next.
- Freeze and length edge cases:
  - en=0 for 3 cycles mid-burst → no acks, cnt unchanged; the burst resumes when en returns.
  - req_len=0 → exactly 1 packet, with burst_done on that ack.
- Async reset mid-burst: rstn pulsed low after ack 1 of 3 → gnt, buf_wen and burst_done are 0 immediately. The next grant goes to requester 0.
